// File: rtl/rx_pkt_drop_fifo_pkg.sv
// Shared types for the ingress drop FIFO: write-side packet framing states.
package rx_pkt_drop_fifo_pkg;

   typedef enum logic [1:0] {
      WR_SYNC,
      WR_FWD,
      WR_DROP
   } wr_state_t;

endpackage

// File: rtl/rx_pkt_drop_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The read register holds its value when no read is issued, so it doubles as an output stage.
module rx_pkt_drop_fifo_ram #(
   parameter int WIDTH      = 73,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

   // NOTE: the storage array is deliberately left without reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/rx_pkt_drop_fifo.sv
// Ingress packet FIFO between a non-stallable MAC RX stream and a scheduler rx_axis port.
// Drops whole packets that are bad, oversize or do not fit; only committed packets are read out.
module rx_pkt_drop_fifo
   import rx_pkt_drop_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int STRB_WIDTH    = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH    = 10,
   parameter int MAX_PKT_WORDS = 200,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [STRB_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [STRB_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic [CNT_WIDTH-1:0]  drop_count,
   output logic [ADDR_WIDTH:0]   fifo_level,
   output logic                  drop_pulse
);

   localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
   localparam int WORD_WIDTH = 1 + STRB_WIDTH + DATA_WIDTH;
   localparam int WCNT_WIDTH = $clog2(MAX_PKT_WORDS + 1);

   localparam logic [PTR_WIDTH-1:0]  FULL_LEVEL = PTR_WIDTH'(2**ADDR_WIDTH);
   localparam logic [WCNT_WIDTH-1:0] WCNT_MAX   = WCNT_WIDTH'(MAX_PKT_WORDS);

   wr_state_t               state;
   logic [PTR_WIDTH-1:0]    wr_ptr;
   logic [PTR_WIDTH-1:0]    wr_commit;
   logic [PTR_WIDTH-1:0]    rd_ptr;
   logic [WCNT_WIDTH-1:0]   word_cnt;
   logic                    full;
   logic                    at_max;
   logic                    wr_en;
   logic                    readable;
   logic                    rd_issue;
   logic [WORD_WIDTH-1:0]   rd_data;

   // full compares against the registered rd_ptr, so a read issued this cycle frees nothing yet
   assign full     = (wr_ptr - rd_ptr) == FULL_LEVEL;
   assign at_max   = word_cnt == WCNT_MAX;
   assign wr_en    = (state == WR_FWD) && s_axis_tvalid && !full && !at_max;
   assign readable = rd_ptr != wr_commit;
   assign rd_issue = readable && (!m_axis_tvalid || m_axis_tready);

   assign fifo_level = wr_ptr - rd_ptr;

   // Write-side framing FSM, pointers and statistics.
   // NOTE: every register here uses <= so all branches see the pre-edge values of wr_ptr/wr_commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WR_SYNC;
         wr_ptr     <= '0;
         wr_commit  <= '0;
         word_cnt   <= '0;
         pkt_count  <= '0;
         drop_count <= '0;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= 1'b0;
         case (state)
            WR_SYNC: begin
               word_cnt <= '0;
               if (!s_axis_tvalid || s_axis_tlast) state <= WR_FWD;
            end
            WR_FWD: begin
               if (s_axis_tvalid) begin
                  if (full || at_max) begin
                     wr_ptr     <= wr_commit;
                     word_cnt   <= '0;
                     drop_count <= drop_count + 1'b1;
                     drop_pulse <= 1'b1;
                     if (!s_axis_tlast) state <= WR_DROP;
                  end else if (s_axis_tlast) begin
                     word_cnt <= '0;
                     if (s_axis_tuser) begin
                        wr_ptr     <= wr_commit;
                        drop_count <= drop_count + 1'b1;
                        drop_pulse <= 1'b1;
                     end else begin
                        wr_ptr    <= wr_ptr + 1'b1;
                        wr_commit <= wr_ptr + 1'b1;
                        pkt_count <= pkt_count + 1'b1;
                     end
                  end else begin
                     wr_ptr   <= wr_ptr + 1'b1;
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            WR_DROP: begin
               word_cnt <= '0;
               if (s_axis_tvalid && s_axis_tlast) state <= WR_FWD;
            end
            default: state <= WR_SYNC;
         endcase
      end
   end

   // The RAM read register is the output skid; m_axis_tvalid tracks whether it holds a word.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr        <= '0;
         m_axis_tvalid <= 1'b0;
      end else begin
         if (rd_issue) begin
            rd_ptr        <= rd_ptr + 1'b1;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   rx_pkt_drop_fifo_ram #(
      .WIDTH      (WORD_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
      .rd_en   (rd_issue),
      .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
      .rd_data (rd_data)
   );

   assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_data;

endmodule

// File: tb/tb_rx_pkt_drop_fifo.sv
// Bench for rx_pkt_drop_fifo: a 16-deep/16-word instance (a) and a 1024-deep/8-word instance (b)
// share one MAC stream and one tready; expected output comes from per-packet queues kept here.
module tb_rx_pkt_drop_fifo;

   localparam int DW = 64;
   localparam int SW = 8;
   localparam int WW = 1 + SW + DW;
   localparam int DEPTH_A = 16;

   typedef logic [WW-1:0] word_t;

   typedef struct {
      logic          v;
      logic          l;
      logic          u;
      logic [DW-1:0] d;
      logic [SW-1:0] k;
      logic          ev;
      word_t         ew;
      int            lvl;
      int            pk;
      int            dc;
      logic          dp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_tdata = '0;
   logic [SW-1:0] s_tkeep = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tuser = 1'b0;
   logic          tready = 1'b1;

   logic [DW-1:0] a_tdata, b_tdata;
   logic [SW-1:0] a_tkeep, b_tkeep;
   logic          a_tvalid, b_tvalid, a_tlast, b_tlast, a_dp, b_dp;
   logic [31:0]   a_pkt, b_pkt, a_drop, b_drop;
   logic [4:0]    a_level;
   logic [10:0]   b_level;
   word_t         a_word, b_word;

   assign a_word = {a_tlast, a_tkeep, a_tdata};
   assign b_word = {b_tlast, b_tkeep, b_tdata};

   always #5 clk = ~clk;

   rx_pkt_drop_fifo #(.ADDR_WIDTH(4), .MAX_PKT_WORDS(16)) dut_a (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tvalid(a_tvalid),
      .m_axis_tready(tready), .m_axis_tlast(a_tlast),
      .pkt_count(a_pkt), .drop_count(a_drop), .fifo_level(a_level), .drop_pulse(a_dp)
   );

   rx_pkt_drop_fifo #(.ADDR_WIDTH(10), .MAX_PKT_WORDS(8)) dut_b (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tvalid(b_tvalid),
      .m_axis_tready(tready), .m_axis_tlast(b_tlast),
      .pkt_count(b_pkt), .drop_count(b_drop), .fifo_level(b_level), .drop_pulse(b_dp)
   );

   int    checks = 0;
   int    errors = 0;
   int    pulses_a = 0;
   int    pulses_b = 0;
   int    chk_a = 0;
   int    chk_b = 0;
   int    seq = 0;
   logic  rand_ready = 1'b0;
   word_t exp_a[$], exp_b[$], got_a[$], got_b[$];
   vec_t  tbl[18];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, log handshakes, then verify held output words after the edge.
   task automatic cyc(input logic v, input logic l, input logic u,
                      input logic [DW-1:0] d, input logic [SW-1:0] k);
      logic  stall_a, stall_b;
      word_t hold_a, hold_b;
      s_tvalid = v; s_tlast = l; s_tuser = u; s_tdata = d; s_tkeep = k;
      if (rand_ready) tready = ($urandom_range(0, 2) != 0);
      if (!rst && a_tvalid && tready) got_a.push_back(a_word);
      if (!rst && b_tvalid && tready) got_b.push_back(b_word);
      stall_a = a_tvalid && !tready; hold_a = a_word;
      stall_b = b_tvalid && !tready; hold_b = b_word;
      @(posedge clk); #1;
      if (stall_a && !rst) check("hold_a", {a_tvalid, a_word}, {1'b1, hold_a});
      if (stall_b && !rst) check("hold_b", {b_tvalid, b_word}, {1'b1, hold_b});
      if (a_dp) pulses_a++;
      if (b_dp) pulses_b++;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic send_pkt(input int len, input logic bad, input logic to_a, input logic to_b,
                           input logic gaps);
      word_t w;
      for (int i = 0; i < len; i++) begin
         w = {i == len - 1, (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF,
              32'(seq), 32'(i)};
         if (to_a) exp_a.push_back(w);
         if (to_b) exp_b.push_back(w);
         if (gaps && $urandom_range(0, 3) == 0) idle();
         cyc(1'b1, w[WW-1], bad && (i == len - 1), w[DW-1:0], w[WW-2:DW]);
      end
      seq++;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((got_a.size() < exp_a.size() || got_b.size() < exp_b.size()) && n < 3000) begin
         idle();
         n++;
      end
      repeat (6) idle();
      check({tag, "_count_a"}, got_a.size(), exp_a.size());
      check({tag, "_count_b"}, got_b.size(), exp_b.size());
      for (int i = chk_a; i < exp_a.size() && i < got_a.size(); i++)
         check($sformatf("%s_word_a%0d", tag, i), got_a[i], exp_a[i]);
      for (int i = chk_b; i < exp_b.size() && i < got_b.size(); i++)
         check($sformatf("%s_word_b%0d", tag, i), got_b[i], exp_b[i]);
      chk_a = exp_a.size();
      chk_b = exp_b.size();
   endtask

   function automatic vec_t mk(input logic v, input logic l, input logic u, input logic [DW-1:0] d,
                               input logic [SW-1:0] k, input logic ev, input word_t ew,
                               input int lvl, input int pk, input int dc, input logic dp);
      vec_t r;
      r.v = v; r.l = l; r.u = u; r.d = d; r.k = k; r.ev = ev; r.ew = ew;
      r.lvl = lvl; r.pk = pk; r.dc = dc; r.dp = dp;
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p_a, p_b, da, db, pa, pb, len, n;
      logic [DW-1:0] w0, w1, w2, w3, g0, g1;

      w0 = 64'h1111_0000_0000_0000; w1 = 64'h1111_0000_0000_0001;
      w2 = 64'h1111_0000_0000_0002; w3 = 64'h1111_0000_0000_0003;
      g0 = 64'h2222_0000_0000_0000; g1 = 64'h2222_0000_0000_0001;

      // Outputs are those seen one edge after the row's inputs; first tvalid lands 2 cycles after tlast.
      tbl[0]  = mk(0, 0, 0, '0, '0,       0, '0,                  0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 0, w0, 8'hFF,    0, '0,                  1, 0, 0, 0);
      tbl[2]  = mk(1, 0, 0, w1, 8'hFF,    0, '0,                  2, 0, 0, 0);
      tbl[3]  = mk(1, 0, 0, w2, 8'hFF,    0, '0,                  3, 0, 0, 0);
      tbl[4]  = mk(1, 1, 0, w3, 8'h3F,    0, '0,                  4, 1, 0, 0);
      tbl[5]  = mk(0, 0, 0, '0, '0,       1, {1'b0, 8'hFF, w0},   3, 1, 0, 0);
      tbl[6]  = mk(0, 0, 0, '0, '0,       1, {1'b0, 8'hFF, w1},   2, 1, 0, 0);
      tbl[7]  = mk(0, 0, 0, '0, '0,       1, {1'b0, 8'hFF, w2},   1, 1, 0, 0);
      tbl[8]  = mk(0, 0, 0, '0, '0,       1, {1'b1, 8'h3F, w3},   0, 1, 0, 0);
      tbl[9]  = mk(0, 0, 0, '0, '0,       0, '0,                  0, 1, 0, 0);
      tbl[10] = mk(1, 0, 0, 64'hBAD0, 8'hFF, 0, '0,               1, 1, 0, 0);
      tbl[11] = mk(1, 0, 0, 64'hBAD1, 8'hFF, 0, '0,               2, 1, 0, 0);
      tbl[12] = mk(1, 1, 1, 64'hBAD2, 8'h01, 0, '0,               0, 1, 1, 1);
      tbl[13] = mk(1, 0, 0, g0, 8'hFF,    0, '0,                  1, 1, 1, 0);
      tbl[14] = mk(1, 1, 0, g1, 8'h0F,    0, '0,                  2, 2, 1, 0);
      tbl[15] = mk(0, 0, 0, '0, '0,       1, {1'b0, 8'hFF, g0},   1, 2, 1, 0);
      tbl[16] = mk(0, 0, 0, '0, '0,       1, {1'b1, 8'h0F, g1},   0, 2, 1, 0);
      tbl[17] = mk(0, 0, 0, '0, '0,       0, '0,                  0, 2, 1, 0);
      foreach (tbl[i]) if (tbl[i].ev) begin
         exp_a.push_back(tbl[i].ew);
         exp_b.push_back(tbl[i].ew);
      end

      // Reset state
      rst = 1'b1;
      repeat (3) idle();
      check("rst_tvalid_a", a_tvalid, 0);
      check("rst_word_a", a_word, 0);
      check("rst_counts_a", {a_pkt, a_drop, a_level, a_dp}, 0);
      check("rst_tvalid_b", b_tvalid, 0);
      check("rst_counts_b", {b_pkt, b_drop, b_level, b_dp}, 0);
      rst = 1'b0;

      // Good 4-word packet, then bad 3-word and good 2-word packets
      tready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         cyc(tbl[i].v, tbl[i].l, tbl[i].u, tbl[i].d, tbl[i].k);
         check($sformatf("tbl%0d_valid_a", i), a_tvalid, tbl[i].ev);
         check($sformatf("tbl%0d_valid_b", i), b_tvalid, tbl[i].ev);
         if (tbl[i].ev) begin
            check($sformatf("tbl%0d_word_a", i), a_word, tbl[i].ew);
            check($sformatf("tbl%0d_word_b", i), b_word, tbl[i].ew);
         end
         check($sformatf("tbl%0d_level_a", i), a_level, tbl[i].lvl);
         check($sformatf("tbl%0d_level_b", i), b_level, tbl[i].lvl);
         check($sformatf("tbl%0d_stats_a", i), {a_pkt, a_drop, a_dp}, {32'(tbl[i].pk), 32'(tbl[i].dc), tbl[i].dp});
         check($sformatf("tbl%0d_stats_b", i), {b_pkt, b_drop, b_dp}, {32'(tbl[i].pk), 32'(tbl[i].dc), tbl[i].dp});
      end
      check("t2_pulses_a", pulses_a, 1);

      // Overflow on the 16-deep instance with the scheduler stalled
      tready = 1'b0;
      p_a = pulses_a; p_b = pulses_b; da = int'(a_drop); db = int'(b_drop);
      send_pkt(10, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) idle();
      // one word of the committed packet already sits in the output register
      check("t3_level_first", a_level, 9);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, i == 9, 1'b0, {32'hC3C3_0000, 32'(i)}, 8'hFF);
         if (i == 6) check("t3_level_full", a_level, 16);
      end
      repeat (2) idle();
      check("t3_level_rollback", a_level, 9);
      check("t3_drops_a", int'(a_drop) - da, 1);
      check("t3_pulses_a", pulses_a - p_a, 1);
      check("t3_valid_held_a", a_tvalid, 1);
      check("t3_drops_b", int'(b_drop) - db, 2);
      check("t3_pulses_b", pulses_b - p_b, 2);
      check("t3_level_b", b_level, 0);
      tready = 1'b1;
      drain("t3");

      // Oversize packet on the 8-word instance, then a normal packet
      da = int'(a_drop); db = int'(b_drop); pa = int'(a_pkt); pb = int'(b_pkt); p_b = pulses_b;
      send_pkt(12, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) idle();
      check("t4_drops_b", int'(b_drop) - db, 1);
      check("t4_pulses_b", pulses_b - p_b, 1);
      check("t4_level_b", b_level, 0);
      send_pkt(3, 1'b0, 1'b1, 1'b1, 1'b0);
      drain("t4");
      check("t4_pkts_a", int'(a_pkt) - pa, 2);
      check("t4_pkts_b", int'(b_pkt) - pb, 1);
      check("t4_drops_a", int'(a_drop) - da, 0);

      // Reset in the middle of a packet with tvalid held high
      cyc(1'b1, 1'b0, 1'b0, 64'hDEAD_0001, 8'hFF);
      cyc(1'b1, 1'b0, 1'b0, 64'hDEAD_0002, 8'hFF);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 64'hDEAD_0003, 8'hFF);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 64'hDEAD_0004, 8'hFF);
      cyc(1'b1, 1'b0, 1'b0, 64'hDEAD_0005, 8'hFF);
      cyc(1'b1, 1'b1, 1'b0, 64'hDEAD_0006, 8'h07);
      repeat (3) idle();
      check("t5_stats_a", {a_pkt, a_drop, a_level, a_tvalid}, 0);
      check("t5_stats_b", {b_pkt, b_drop, b_level, b_tvalid}, 0);
      send_pkt(4, 1'b0, 1'b1, 1'b1, 1'b0);
      drain("t5");
      check("t5_counts_a", {a_pkt, a_drop}, {32'd1, 32'd0});
      check("t5_counts_b", {b_pkt, b_drop}, {32'd1, 32'd0});

      // 64 good packets with random tready, gaps and lengths, paced to fit the 16-word buffer
      rst = 1'b1;
      repeat (2) idle();
      rst = 1'b0;
      idle();
      p_a = pulses_a; p_b = pulses_b;
      rand_ready = 1'b1;
      for (int p = 0; p < 64; p++) begin
         len = $urandom_range(1, 8);
         n = 0;
         while ((exp_a.size() - got_a.size()) + len > DEPTH_A && n < 2000) begin
            idle();
            n++;
         end
         send_pkt(len, 1'b0, 1'b1, 1'b1, 1'b1);
         repeat ($urandom_range(0, 2)) idle();
      end
      drain("t6");
      rand_ready = 1'b0;
      tready = 1'b1;
      check("t6_counts_a", {a_pkt, a_drop}, {32'd64, 32'd0});
      check("t6_counts_b", {b_pkt, b_drop}, {32'd64, 32'd0});
      check("t6_pulses", {32'(pulses_a - p_a), 32'(pulses_b - p_b)}, 0);
      check("t6_level", {a_level, b_level}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
